game_turn_ctrl: RTL and testbench

- Sequencing controller for the nine per-square draw stages of the tic-tac-toe board.
- Accepts move requests (square index 1..9) from the input decoder. Rejects moves to occupied or invalid squares and alternates players.
- Drives square_en[8:0] and square_color[8:0], which feed the squareN / squareN_color inputs of the draw chain.
- Detects win, draw and game-over, and reports the result to the screen/menu logic.

---
 rtl/game_turn_ctrl_pkg.sv | 37 +++
 rtl/game_turn_ctrl_win_detect.sv | 25 ++
 rtl/game_turn_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_game_turn_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_turn_ctrl_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller:
// colour codes, FSM states, winner codes and the win-line table.
package game_pkg;

  localparam logic COLOR_BLUE   = 1'b0;
  localparam logic COLOR_YELLOW = 1'b1;

  localparam logic [11:0] RGB_BLUE   = 12'h00f;
  localparam logic [11:0] RGB_YELLOW = 12'hff0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK_MOVE,
    ST_EVAL,
    ST_DONE
  } state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_BLUE   = 2'b01;
  localparam logic [1:0] WIN_YELLOW = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

  localparam int NUM_LINES = 8;

  // Bit k-1 is square k, squares numbered row-major from the top-left.
  localparam logic [8:0] WIN_LINES [0:NUM_LINES-1] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  function automatic logic [1:0] win_code(input logic colour);
    return (colour == COLOR_YELLOW) ? WIN_YELLOW : WIN_BLUE;
  endfunction

endpackage

// File: rtl/game_turn_ctrl_win_detect.sv
// Combinational check: does any of the eight lines hold three squares
// of the given colour?
module win_detect
  import game_pkg::*;
(
  input  logic [8:0] square_en,
  input  logic [8:0] square_color,
  input  logic       colour,
  output logic       line_hit
);

  always_comb begin
    line_hit = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if ((square_en & WIN_LINES[i]) == WIN_LINES[i]) begin
        if (colour == COLOR_YELLOW) begin
          if ((square_color & WIN_LINES[i]) == WIN_LINES[i]) line_hit = 1'b1;
        end else begin
          if ((square_color & WIN_LINES[i]) == 9'd0) line_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for the tic-tac-toe board: debounces move requests,
// validates squares, alternates players and reports win/draw.
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | menu active or game not started; requests ignored
// WAIT       | waiting for a qualified move request
// CHECK_MOVE | validate latched index, place piece or reject
// EVAL       | look for a completed line or a full board
// DONE       | game over, board frozen, requests rejected
module game_turn_ctrl
  import game_pkg::*;
#(
  parameter logic FIRST_COLOR = 1'b0,
  parameter int   MOVE_GUARD  = 4
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       start_en,
  input  logic       choice_en,
  input  logic       new_game,
  input  logic       move_req,
  input  logic [3:0] move_idx,
  output logic [8:0] square_en,
  output logic [8:0] square_color,
  output logic       turn,
  output logic       move_ack,
  output logic       move_err,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int GW = $clog2(MOVE_GUARD + 1);
  localparam logic [GW-1:0] GUARD_MAX = GW'(MOVE_GUARD);

  state_t        state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    move_cnt_q, move_cnt_d;
  logic [8:0]    square_en_q, square_en_d;
  logic [8:0]    square_color_q, square_color_d;
  logic          turn_q, turn_d;
  logic          move_ack_q, move_ack_d;
  logic          move_err_q, move_err_d;
  logic          game_over_q, game_over_d;
  logic [1:0]    winner_q, winner_d;

  logic       qual_edge;
  logic       go_active;
  logic       idx_valid;
  logic [8:0] idx_mask;
  logic       line_hit;

  win_detect u_win_detect (
    .square_en    (square_en_q),
    .square_color (square_color_q),
    .colour       (turn_q),
    .line_hit     (line_hit)
  );

  // A saturated low-count means move_req was low long enough, so a high
  // level now is itself the rising edge.
  assign qual_edge = move_req && (guard_q == GUARD_MAX);
  assign go_active = start_en && !choice_en;
  assign idx_valid = (idx_q != 4'd0) && (idx_q <= 4'd9);
  assign idx_mask  = idx_valid ? (9'd1 << (idx_q - 4'd1)) : 9'd0;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    move_cnt_d     = move_cnt_q;
    square_en_d    = square_en_q;
    square_color_d = square_color_q;
    turn_d         = turn_q;
    move_ack_d     = 1'b0;
    move_err_d     = 1'b0;
    game_over_d    = game_over_q;
    winner_d       = winner_q;

    if (move_req) begin
      guard_d = '0;
    end else if (guard_q == GUARD_MAX) begin
      guard_d = guard_q;
    end else begin
      guard_d = guard_q + GW'(1);
    end

    if (new_game) begin
      square_en_d    = 9'd0;
      square_color_d = 9'd0;
      turn_d         = FIRST_COLOR;
      winner_d       = WIN_NONE;
      game_over_d    = 1'b0;
      move_cnt_d     = 4'd0;
      state_d        = go_active ? ST_WAIT : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_active) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (!go_active) begin
            state_d = ST_IDLE;
          end else if (qual_edge) begin
            idx_d   = move_idx;
            state_d = ST_CHECK_MOVE;
          end
        end
        ST_CHECK_MOVE: begin
          if (!idx_valid || ((square_en_q & idx_mask) != 9'd0)) begin
            move_err_d = 1'b1;
            state_d    = ST_WAIT;
          end else begin
            square_en_d    = square_en_q | idx_mask;
            square_color_d = turn_q ? (square_color_q | idx_mask)
                                    : (square_color_q & ~idx_mask);
            move_ack_d     = 1'b1;
            move_cnt_d     = move_cnt_q + 4'd1;
            state_d        = ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (line_hit) begin
            winner_d    = win_code(turn_q);
            game_over_d = 1'b1;
            state_d     = ST_DONE;
          end else if (move_cnt_q == 4'd9) begin
            winner_d    = WIN_DRAW;
            game_over_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            turn_d  = ~turn_q;
            state_d = ST_WAIT;
          end
        end
        ST_DONE: begin
          if (qual_edge) move_err_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      guard_q        <= '0;
      idx_q          <= 4'd0;
      move_cnt_q     <= 4'd0;
      square_en_q    <= 9'd0;
      square_color_q <= 9'd0;
      turn_q         <= FIRST_COLOR;
      move_ack_q     <= 1'b0;
      move_err_q     <= 1'b0;
      game_over_q    <= 1'b0;
      winner_q       <= WIN_NONE;
    end else begin
      state_q        <= state_d;
      guard_q        <= guard_d;
      idx_q          <= idx_d;
      move_cnt_q     <= move_cnt_d;
      square_en_q    <= square_en_d;
      square_color_q <= square_color_d;
      turn_q         <= turn_d;
      move_ack_q     <= move_ack_d;
      move_err_q     <= move_err_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
    end
  end

  assign square_en    = square_en_q;
  assign square_color = square_color_q;
  assign turn         = turn_q;
  assign move_ack     = move_ack_q;
  assign move_err     = move_err_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench for game_turn_ctrl: expected ack/err outcomes are queued
// per request and compared against pulses counted after each request.
module tb_game_turn_ctrl;

  localparam int EXP_NONE = 0;
  localparam int EXP_ACK  = 1;
  localparam int EXP_ERR  = 2;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       start_en = 1'b0;
  logic       choice_en = 1'b0;
  logic       new_game = 1'b0;
  logic       move_req = 1'b0;
  logic [3:0] move_idx = 4'd0;
  logic [8:0] square_en;
  logic [8:0] square_color;
  logic       turn;
  logic       move_ack;
  logic       move_err;
  logic       game_over;
  logic [1:0] winner;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int sb[$];

  game_turn_ctrl #(.FIRST_COLOR(1'b0), .MOVE_GUARD(4)) dut (
    .pclk         (pclk),
    .rst          (rst),
    .start_en     (start_en),
    .choice_en    (choice_en),
    .new_game     (new_game),
    .move_req     (move_req),
    .move_idx     (move_idx),
    .square_en    (square_en),
    .square_color (square_color),
    .turn         (turn),
    .move_ack     (move_ack),
    .move_err     (move_err),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (move_ack === 1'b1) ack_cnt = ack_cnt + 1;
    if (move_err === 1'b1) err_cnt = err_cnt + 1;
    if (move_ack === 1'b1 && move_err === 1'b1) both_cnt = both_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic score(input string tag, input int a0, input int e0);
    int exp;
    if (sb.size() == 0) begin
      total_cnt++;
      $error("FAIL %s observed=empty expected=queued", tag);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_ack"}, ack_cnt - a0, (exp == EXP_ACK) ? 1 : 0);
      chk({tag, "_err"}, err_cnt - e0, (exp == EXP_ERR) ? 1 : 0);
    end
  endtask

  task automatic do_move(input string tag, input logic [3:0] idx, input int exp);
    int a0, e0;
    a0 = ack_cnt;
    e0 = err_cnt;
    sb.push_back(exp);
    move_idx = idx;
    move_req = 1'b1;
    tick(1);
    move_req = 1'b0;
    tick(8);
    score(tag, a0, e0);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    tick(6);
  endtask

  initial begin
    int a0, e0;

    tick(2);
    chk("rst_sq_en", square_en, 0);
    chk("rst_sq_col", square_color, 0);
    chk("rst_turn", turn, 0);
    chk("rst_winner", winner, 0);
    chk("rst_over", game_over, 0);
    chk("rst_ackerr", {move_ack, move_err}, 0);
    rst = 1'b0;
    tick(6);

    do_move("idle_drop", 4'd1, EXP_NONE);
    chk("idle_sq_en", square_en, 0);

    start_en = 1'b1;
    tick(2);
    do_move("a_m1", 4'd1, EXP_ACK);
    do_move("a_m4", 4'd4, EXP_ACK);
    do_move("a_m2", 4'd2, EXP_ACK);
    do_move("a_m5", 4'd5, EXP_ACK);
    do_move("a_m3", 4'd3, EXP_ACK);
    chk("a_sq_en", square_en, 'h01F);
    chk("a_sq_col", square_color, 'h018);
    chk("a_winner", winner, 1);
    chk("a_over", game_over, 1);
    chk("a_turn", turn, 0);
    do_move("a_after", 4'd6, EXP_ERR);
    chk("a_frozen", square_en, 'h01F);

    a0 = ack_cnt;
    e0 = err_cnt;
    sb.push_back(EXP_NONE);
    new_game = 1'b1;
    move_req = 1'b1;
    move_idx = 4'd6;
    tick(1);
    new_game = 1'b0;
    move_req = 1'b0;
    tick(8);
    score("ng_edge", a0, e0);
    chk("ng_sq_en", square_en, 0);
    chk("ng_sq_col", square_color, 0);
    chk("ng_winner", winner, 0);
    chk("ng_over", game_over, 0);
    chk("ng_turn", turn, 0);

    a0 = ack_cnt;
    e0 = err_cnt;
    sb.push_back(EXP_ACK);
    move_idx = 4'd5;
    move_req = 1'b1;
    tick(1);
    move_req = 1'b0;
    @(negedge pclk);
    chk("lat_p1", square_en, 0);
    @(posedge pclk);
    @(negedge pclk);
    chk("lat_p2", square_en, 'h010);
    chk("lat_ack", move_ack, 1);
    tick(7);
    score("b_m5", a0, e0);
    do_move("b_m5_again", 4'd5, EXP_ERR);
    chk("b_sq_en", square_en, 'h010);
    chk("b_turn", turn, 1);
    do_move("b_idx0", 4'd0, EXP_ERR);
    do_move("b_idx12", 4'd12, EXP_ERR);
    chk("b_sq_en2", square_en, 'h010);
    chk("b_sq_col", square_color, 0);
    chk("b_turn2", turn, 1);

    choice_en = 1'b1;
    tick(2);
    do_move("b_choice", 4'd6, EXP_NONE);
    chk("b_choice_sq", square_en, 'h010);
    choice_en = 1'b0;
    tick(2);

    pulse_new_game();
    do_move("c_m1", 4'd1, EXP_ACK);
    do_move("c_m2", 4'd2, EXP_ACK);
    do_move("c_m3", 4'd3, EXP_ACK);
    do_move("c_m5", 4'd5, EXP_ACK);
    do_move("c_m4", 4'd4, EXP_ACK);
    do_move("c_m6", 4'd6, EXP_ACK);
    do_move("c_m8", 4'd8, EXP_ACK);
    do_move("c_m7", 4'd7, EXP_ACK);
    chk("c_not_over", game_over, 0);
    do_move("c_m9", 4'd9, EXP_ACK);
    chk("c_sq_en", square_en, 'h1FF);
    chk("c_sq_col", square_color, 'h072);
    chk("c_winner", winner, 3);
    chk("c_over", game_over, 1);
    do_move("c_after", 4'd1, EXP_ERR);

    pulse_new_game();
    a0 = ack_cnt;
    e0 = err_cnt;
    sb.push_back(EXP_ACK);
    move_idx = 4'd1;
    move_req = 1'b1;
    tick(20);
    move_req = 1'b0;
    tick(2);
    move_req = 1'b1;
    tick(5);
    move_req = 1'b0;
    tick(8);
    score("hold", a0, e0);
    chk("hold_sq_en", square_en, 'h001);

    move_idx = 4'd2;
    move_req = 1'b1;
    tick(1);
    move_req = 1'b0;
    tick(1);
    chk("eval_sq_en", square_en, 'h003);
    chk("eval_sq_col", square_color, 'h002);
    rst = 1'b1;
    #1;
    chk("mid_rst_sq_en", square_en, 0);
    chk("mid_rst_sq_col", square_color, 0);
    chk("mid_rst_turn", turn, 0);
    chk("mid_rst_ackerr", {move_ack, move_err}, 0);
    chk("mid_rst_over", {game_over, winner}, 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    chk("ack_err_excl", both_cnt, 0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
